hilo_muldiv: RTL

Iterative multiply/divide unit with the HI/LO register pair for the MIPS core. Sits directly downstream of the register file: consumes the two read ports (rs, rt) for MULT/MULTU/DIV/DIVU and MTHI/MTLO. Supplies HI/LO back to the WriteData path for MFHI/MFLO. Radix-2, one bit per cycle, fixed latency, Busy/Done handshake toward the control unit.

---
 rtl/hilo_muldiv_pkg.sv | 33 +++
 rtl/hilo_muldiv_if.sv | 35 +++
 rtl/hilo_muldiv_iter.sv | 82 ++++++++
 rtl/hilo_muldiv.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   MD_WIDTH  - operand and HI/LO width
//   MD_ITERS  - radix-2 iterations per operation
//   op_e      - operation encodings as carried on the op field
//   state_e   - control FSM states
//   is_div_op / is_signed_op - operation decode helpers
package hilo_muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  function automatic logic is_div_op(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Control-unit / register-file side bus of the multiply/divide unit.
//   start, op, src_a, src_b   - operation launch (sampled only while idle)
//   mt_we, mt_sel, mt_data    - MTHI (mt_sel=1) / MTLO (mt_sel=0) write
//   busy, done                - operation in progress / one-cycle completion pulse
//   hi, lo                    - registered HI/LO values
// master: control unit side; slave: the multiply/divide unit.
interface hilo_muldiv_if
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mt_we;
  logic             mt_sel;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, mt_we, mt_sel, mt_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, mt_we, mt_sel, mt_data,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_iter.sv
// Radix-2 datapath: one multiply or restoring-divide step per enable, sharing a
// single WIDTH+1 bit adder/subtractor.
//   clk, rst_n - clock, synchronous active-low reset
//   load       - initialise working register from the operand magnitudes
//   en         - perform one iteration
//   is_div     - divide step (1) or multiply step (0); also selects load layout
//   a_mag      - multiplicand / dividend magnitude
//   b_mag      - multiplier / divisor magnitude
//   work       - {acc, multiplier} for multiply, {remainder, quotient} for divide
module hilo_muldiv_iter
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] work
);

  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     add_a, add_b, sum;
  logic               add_cin;
  logic               rem_ge;

  always_comb begin
    // Partial remainder shifted left by one, taking the next dividend bit.
    rem_sh = work_q[2*WIDTH-1:WIDTH-1];
    if (is_div) begin
      add_a   = rem_sh;
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, work_q[2*WIDTH-1:WIDTH]};
      add_b   = {1'b0, opnd_q};
      add_cin = 1'b0;
    end
    sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    // If the shifted remainder overflowed WIDTH bits it certainly exceeds the
    // divisor; otherwise the subtractor's top bit is a valid sign.
    rem_ge = rem_sh[WIDTH] | ~sum[WIDTH];

    work_d = work_q;
    opnd_d = opnd_q;
    if (load) begin
      if (is_div) begin
        work_d = {{WIDTH{1'b0}}, a_mag};
        opnd_d = b_mag;
      end else begin
        work_d = {{WIDTH{1'b0}}, b_mag};
        opnd_d = a_mag;
      end
    end else if (en) begin
      if (is_div) begin
        work_d = {(rem_ge ? sum[WIDTH-1:0] : rem_sh[WIDTH-1:0]), work_q[WIDTH-2:0], rem_ge};
      end else if (work_q[0]) begin
        work_d = {sum, work_q[WIDTH-1:1]};
      end else begin
        work_d = {1'b0, work_q[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q <= '0;
      opnd_q <= '0;
    end else begin
      work_q <= work_d;
      opnd_q <= opnd_d;
    end
  end

  assign work = work_q;

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with the HI/LO register pair.
//   Clk   - core clock
//   Rst_n - synchronous active-low reset
//   bus   - slave side of hilo_muldiv_if (launch, MTHI/MTLO, busy/done, hi/lo)
// Fixed 33-cycle latency from the start edge to the done pulse; operands are
// captured as magnitudes at start and the signs are applied in FIX.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic Clk,
  input  logic Rst_n,
  hilo_muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             neg_res_q, neg_res_d;    // product / quotient negation
  logic             neg_rem_q, neg_rem_d;    // remainder follows dividend sign
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] src_a_q, src_a_d;        // raw dividend for divide-by-zero HI
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  op_e                op_in;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               iter_load, iter_en, iter_div;
  logic [2*WIDTH-1:0] work, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign op_in = op_e'(bus.op);
  assign a_neg = is_signed_op(op_in) & bus.src_a[WIDTH-1];
  assign b_neg = is_signed_op(op_in) & bus.src_b[WIDTH-1];
  // abs(most-negative) wraps to itself, which is the correct unsigned magnitude.
  assign a_mag = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag = b_neg ? -bus.src_b : bus.src_b;

  // At load time the layout follows the incoming op, afterwards the latched one.
  assign iter_div = (state_q == IDLE) ? is_div_op(op_in) : is_div_op(op_q);

  hilo_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .load   (iter_load),
    .en     (iter_en),
    .is_div (iter_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .work   (work)
  );

  assign prod = neg_res_q ? -work : work;
  assign quo  = neg_res_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
  assign rem  = neg_rem_q ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    src_a_d    = src_a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    iter_load  = 1'b0;
    iter_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          iter_load  = 1'b1;
          op_d       = op_in;
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          div_zero_d = is_div_op(op_in) && (bus.src_b == '0);
          src_a_d    = bus.src_a;
          cnt_d      = '0;
          state_d    = RUN;
        end else if (bus.mt_we) begin
          if (bus.mt_sel) hi_d = bus.mt_data;
          else            lo_d = bus.mt_data;
        end
      end
      RUN: begin
        iter_en = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!is_div_op(op_q)) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = src_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      src_a_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      src_a_q    <= src_a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
